// File: rtl/pe_nic.sv
// PE network interface: TX FIFO with VC-slot-gated injection into the router
// PE port, RX FIFO draining router ejections, saturating traffic counters.
module pe_nic #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_valid,
   input  logic [63:0]      tx_data,
   output logic             tx_ready,
   output logic             rx_valid,
   output logic [63:0]      rx_data,
   input  logic             rx_ready,
   output logic             si_PE,
   output logic [63:0]      PE_in_packet,
   input  logic             ri_PE,
   input  logic             so_PE,
   input  logic [63:0]      PE_out_packet,
   output logic             ro_PE,
   input  logic             polarity,
   output logic [CNT_W-1:0] tx_count,
   output logic [CNT_W-1:0] rx_count,
   output logic             rx_overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WAIT_SLOT, SEND} inj_state_e;

   logic [63:0]      tx_mem_q [FIFO_DEPTH];
   logic [63:0]      tx_mem_d [FIFO_DEPTH];
   logic [63:0]      rx_mem_q [FIFO_DEPTH];
   logic [63:0]      rx_mem_d [FIFO_DEPTH];
   logic [AW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] tx_count_q, tx_count_d;
   logic [CNT_W-1:0] rx_count_q, rx_count_d;
   logic             rx_ovr_q, rx_ovr_d;

   inj_state_e  state;
   logic        tx_empty, tx_full, rx_empty, rx_full;
   logic        tx_push, tx_pop, rx_push, rx_pop;
   logic [63:0] tx_head, rx_head;

   // Handshake outputs are forced low while reset is held.
   always_comb begin
      tx_empty = (tx_cnt_q == '0);
      tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
      rx_empty = (rx_cnt_q == '0);
      rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
      tx_head  = tx_mem_q[tx_rp_q];
      rx_head  = rx_mem_q[rx_rp_q];
      state    = IDLE;
      if (!tx_empty) begin
         if (tx_head[63] == polarity) state = SEND;
         else                         state = WAIT_SLOT;
      end
      tx_ready     = reset && !tx_full;
      ro_PE        = reset && !rx_full;
      rx_valid     = reset && !rx_empty;
      si_PE        = reset && (state == SEND);
      rx_data      = rx_valid ? rx_head : 64'h0;
      PE_in_packet = (reset && !tx_empty) ? tx_head : 64'h0;
      tx_push      = tx_valid && tx_ready;
      tx_pop       = si_PE && ri_PE;
      rx_push      = so_PE && ro_PE;
      rx_pop       = rx_valid && rx_ready;
      tx_count     = tx_count_q;
      rx_count     = rx_count_q;
      rx_overrun   = rx_ovr_q;
   end

   always_comb begin
      tx_mem_d   = tx_mem_q;
      rx_mem_d   = rx_mem_q;
      tx_wp_d    = tx_wp_q;
      tx_rp_d    = tx_rp_q;
      rx_wp_d    = rx_wp_q;
      rx_rp_d    = rx_rp_q;
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      tx_count_d = tx_count_q;
      rx_count_d = rx_count_q;
      rx_ovr_d   = rx_ovr_q || (so_PE && !ro_PE);
      if (tx_push) begin
         tx_mem_d[tx_wp_q] = tx_data;
         tx_wp_d = tx_wp_q + AW'(1);
      end
      if (tx_pop) begin
         tx_rp_d = tx_rp_q + AW'(1);
         if (tx_count_q != {CNT_W{1'b1}})
            tx_count_d = tx_count_q + CNT_W'(1);
      end
      if (rx_push) begin
         rx_mem_d[rx_wp_q] = PE_out_packet;
         rx_wp_d = rx_wp_q + AW'(1);
         if (rx_count_q != {CNT_W{1'b1}})
            rx_count_d = rx_count_q + CNT_W'(1);
      end
      if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
      if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
      if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         tx_count_q <= '0;
         rx_count_q <= '0;
         rx_ovr_q   <= 1'b0;
      end else begin
         tx_wp_q    <= tx_wp_d;
         tx_rp_q    <= tx_rp_d;
         rx_wp_q    <= rx_wp_d;
         rx_rp_q    <= rx_rp_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_count_q <= tx_count_d;
         rx_count_q <= rx_count_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

endmodule

// File: tb/tb_pe_nic.sv
// Directed bench for pe_nic with a queue scoreboard checked every cycle.
module tb_pe_nic;

   localparam int D = 4;
   localparam int CW = 4;
   localparam int SAT = 15;

   logic          clk = 1'b0;
   logic          reset, tx_valid, rx_ready, ri_PE, so_PE, polarity;
   logic [63:0]   tx_data, PE_out_packet;
   logic          tx_ready, rx_valid, si_PE, ro_PE, rx_overrun;
   logic [63:0]   rx_data, PE_in_packet;
   logic [CW-1:0] tx_count, rx_count;

   logic [63:0] txq[$];
   logic [63:0] rxq[$];
   int  tx_cnt_m, rx_cnt_m, tx_acc;
   bit  ovr_m, mdl_rst;
   int  checks, errors;

   always #5 clk = ~clk;

   pe_nic #(.FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .si_PE(si_PE), .PE_in_packet(PE_in_packet), .ri_PE(ri_PE),
      .so_PE(so_PE), .PE_out_packet(PE_out_packet), .ro_PE(ro_PE),
      .polarity(polarity), .tx_count(tx_count), .rx_count(rx_count),
      .rx_overrun(rx_overrun)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs before the edge, advance the model, then edge.
   task automatic cycle();
      logic        e_si, e_txr, e_ror, e_rxv;
      logic [63:0] e_pin, e_rxd;
      @(negedge clk);
      if (!reset) begin
         chk("rst_tx_ready", tx_ready, 0);
         chk("rst_ro_PE", ro_PE, 0);
         chk("rst_si_PE", si_PE, 0);
         chk("rst_rx_valid", rx_valid, 0);
         if (mdl_rst) begin
            chk("rst_PE_in_packet", PE_in_packet, 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_tx_count", tx_count, 0);
            chk("rst_rx_count", rx_count, 0);
            chk("rst_rx_overrun", rx_overrun, 0);
         end
         txq.delete();
         rxq.delete();
         tx_cnt_m = 0;
         rx_cnt_m = 0;
         ovr_m = 0;
         mdl_rst = 1;
      end else begin
         mdl_rst = 0;
         e_txr = txq.size() < D;
         e_ror = rxq.size() < D;
         e_pin = (txq.size() > 0) ? txq[0] : 64'h0;
         e_si  = (txq.size() > 0) ? (e_pin[63] == polarity) : 1'b0;
         e_rxv = rxq.size() > 0;
         e_rxd = e_rxv ? rxq[0] : 64'h0;
         chk("tx_ready", tx_ready, e_txr);
         chk("ro_PE", ro_PE, e_ror);
         chk("si_PE", si_PE, e_si);
         chk("PE_in_packet", PE_in_packet, e_pin);
         chk("rx_valid", rx_valid, e_rxv);
         chk("rx_data", rx_data, e_rxd);
         chk("tx_count", tx_count, tx_cnt_m);
         chk("rx_count", rx_count, rx_cnt_m);
         chk("rx_overrun", rx_overrun, ovr_m);
         if (e_si && ri_PE) begin
            void'(txq.pop_front());
            if (tx_cnt_m < SAT) tx_cnt_m++;
         end
         if (tx_valid && e_txr) begin
            txq.push_back(tx_data);
            tx_acc++;
         end
         if (e_rxv && rx_ready) void'(rxq.pop_front());
         if (so_PE && e_ror) begin
            rxq.push_back(PE_out_packet);
            if (rx_cnt_m < SAT) rx_cnt_m++;
         end
         if (so_PE && !e_ror) ovr_m = 1;
      end
      @(posedge clk);
      #1;
      polarity = ~polarity;
   endtask

   task automatic drain_tx();
      int n = 0;
      while (txq.size() > 0 && n < 100) begin
         cycle();
         n++;
      end
      chk("tx_drain_timeout", txq.size(), 0);
   endtask

   task automatic drain_rx();
      int n = 0;
      rx_ready = 1;
      while (rxq.size() > 0 && n < 100) begin
         cycle();
         n++;
      end
      rx_ready = 0;
      chk("rx_drain_timeout", rxq.size(), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tx_cnt_m = 0;
      rx_cnt_m = 0;
      tx_acc = 0;
      ovr_m = 0;
      mdl_rst = 0;
      reset = 0;
      tx_valid = 1;
      tx_data = 64'h1234_5678_9abc_def0;
      rx_ready = 0;
      ri_PE = 0;
      so_PE = 0;
      PE_out_packet = 64'h0;
      polarity = 0;

      // reset held three cycles with tx_valid high
      repeat (3) cycle();
      reset = 1;
      tx_valid = 0;
      cycle();
      chk("post_rst_tx_ready", tx_ready, 1);

      // polarity gating of a single VC1 packet
      ri_PE = 1;
      tx_valid = 1;
      tx_data = 64'h8000_0000_0000_00AA;
      cycle();
      tx_valid = 0;
      repeat (4) cycle();
      chk("single_tx_count", tx_count, 1);

      // router stall with four queued packets plus one refused
      ri_PE = 0;
      tx_valid = 1;
      for (int i = 0; i < 5; i++) begin
         tx_data = {i[0], 59'h0, i[3:0]} + 64'h0B00;
         cycle();
      end
      tx_valid = 0;
      cycle();
      chk("stall_tx_ready", tx_ready, 0);
      ri_PE = 1;
      drain_tx();
      chk("stall_tx_count", tx_count, 5);

      // RX fill and overrun
      so_PE = 1;
      for (int i = 0; i < 5; i++) begin
         PE_out_packet = 64'hC0DE_0000_0000_0000 | 64'(i);
         cycle();
      end
      so_PE = 0;
      cycle();
      chk("fill_rx_overrun", rx_overrun, 1);
      chk("fill_rx_count", rx_count, 4);
      chk("fill_ro_PE", ro_PE, 0);
      drain_rx();

      // simultaneous push/pop across pointer wrap
      so_PE = 1;
      for (int i = 0; i < 2; i++) begin
         PE_out_packet = 64'hD000_0000_0000_0000 | 64'(i);
         cycle();
      end
      rx_ready = 1;
      for (int i = 2; i < 12; i++) begin
         PE_out_packet = 64'hD000_0000_0000_0000 | 64'(i * 3);
         cycle();
         chk("simul_rx_valid", rx_valid, 1);
      end
      so_PE = 0;
      drain_rx();

      // tx_count saturation with alternating-VC traffic
      tx_acc = 0;
      tx_valid = 1;
      for (int n = 0; n < 200 && tx_acc < 20; n++) begin
         tx_data = {tx_acc[0], 55'h0, tx_acc[7:0]};
         cycle();
      end
      tx_valid = 0;
      chk("sat_accepted", tx_acc, 20);
      drain_tx();
      chk("sat_tx_count", tx_count, SAT);
      chk("sat_rx_count", rx_count, SAT);

      // reset while a packet is stalled in the TX FIFO
      ri_PE = 0;
      tx_valid = 1;
      tx_data = 64'hFEED_0000_0000_0001;
      cycle();
      tx_valid = 0;
      reset = 0;
      cycle();
      reset = 1;
      cycle();
      chk("midrst_PE_in_packet", PE_in_packet, 0);
      chk("midrst_tx_count", tx_count, 0);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
